// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver state encoding, frame constants and
// default conditioning/timeout values reused by host-side PS/2 blocks.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_rx_state_e;

    localparam int   PS2_DATA_BITS = 8;
    localparam logic PS2_START     = 1'b0;
    localparam logic PS2_STOP      = 1'b1;

    localparam int PS2_FILT_LEN_DEF    = 4;
    localparam int PS2_TIMEOUT_CYC_DEF = 4800;

endpackage

// File: rtl/ps2_rx_fifo.sv
// First-word fall-through byte FIFO with flush, occupancy count and a
// drop indication when a push finds it full without a same-cycle pop.
module ps2_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic [W-1:0]               din_i,
    input  logic                       pop_i,
    output logic [W-1:0]               dout_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       ovf_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [W-1:0]  last_q;
    logic          empty;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty;
    assign do_push = push_i && (!full || do_pop);
    assign ovf_o   = push_i && full && !do_pop && !clr_i;

    always_ff @(posedge clk_i) begin
        if (do_push && !clr_i) begin
            mem[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            // last_q tracks the head so data_o keeps its value once drained
            if (!empty) begin
                last_q <= mem[rd_ptr_q];
            end
            if (clr_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr_q <= wr_ptr_q + PW'(1);
                end
                if (do_pop) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
                case ({do_push, do_pop})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    assign dout_o  = empty ? last_q : mem[rd_ptr_q];
    assign valid_o = !empty;
    assign count_o = count_q;

endmodule

// File: rtl/ps2_host_rx.sv
// Host-side PS/2 receiver: pad synchronisers, ps2_clk glitch filter, frame
// FSM with inactivity timeout, and a byte FIFO for the bus wrapper.
module ps2_host_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int FILT_LEN    = PS2_FILT_LEN_DEF,
    parameter int TIMEOUT_CYC = PS2_TIMEOUT_CYC_DEF
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          en_i,
    input  logic                          clr_i,
    input  logic                          ps2_clk_i,
    input  logic                          ps2_dat_i,
    input  logic                          rd_i,
    output logic [7:0]                    data_o,
    output logic                          valid_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          par_err_o,
    output logic                          frm_err_o,
    output logic                          ovf_o,
    output logic                          irq_o
);
    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic clk_s1, clk_s2, dat_s1, dat_s2;
    logic          filt_lvl;
    logic [FW-1:0] filt_cnt;
    logic          fe;

    ps2_rx_state_e state_q, state_d;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic [TW-1:0] tmo_cnt_q;
    logic          timeout;
    logic          push_q, push_d;
    logic          frm_q, frm_d;
    logic          par_err_q, par_err_d;
    logic          ovf_q;
    logic          fifo_ovf;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk_i;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_dat_i;
            dat_s2 <= dat_s1;
        end
    end

    // Down-counter runs while the synced level disagrees with the filtered one
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            filt_lvl <= 1'b1;
            filt_cnt <= FW'(FILT_LEN - 1);
        end else if (clk_s2 == filt_lvl) begin
            filt_cnt <= FW'(FILT_LEN - 1);
        end else if (filt_cnt == '0) begin
            filt_lvl <= clk_s2;
            filt_cnt <= FW'(FILT_LEN - 1);
        end else begin
            filt_cnt <= filt_cnt - FW'(1);
        end
    end

    assign fe      = filt_lvl && !clk_s2 && (filt_cnt == '0);
    assign timeout = (state_q != IDLE) && !fe && (tmo_cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        frm_d     = 1'b0;
        par_err_d = 1'b0;
        push_d    = 1'b0;
        if (!en_i) begin
            state_d = IDLE;
        end else if (timeout) begin
            state_d = IDLE;
            frm_d   = 1'b1;
        end else if (fe) begin
            case (state_q)
                IDLE: begin
                    if (dat_s2 == PS2_START) state_d = DATA;
                    else                     frm_d   = 1'b1;
                end
                DATA: begin
                    if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) state_d = PARITY;
                end
                PARITY: state_d = STOP;
                STOP: begin
                    state_d = IDLE;
                    if (dat_s2 != PS2_STOP)       frm_d     = 1'b1;
                    else if (!(^{shift_q, par_q})) par_err_d = 1'b1;
                    else                          push_d    = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tmo_cnt_q <= TW'(TIMEOUT_CYC - 1);
            push_q    <= 1'b0;
            frm_q     <= 1'b0;
            par_err_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            push_q    <= push_d;
            frm_q     <= frm_d;
            par_err_q <= par_err_d;
            ovf_q     <= fifo_ovf;
            if (state_q != DATA) begin
                bit_cnt_q <= '0;
            end else if (fe && en_i) begin
                shift_q[bit_cnt_q] <= dat_s2;
                bit_cnt_q          <= bit_cnt_q + 3'd1;
            end
            if (fe && en_i && state_q == PARITY) begin
                par_q <= dat_s2;
            end
            if (fe || state_q == IDLE) begin
                tmo_cnt_q <= TW'(TIMEOUT_CYC - 1);
            end else if (tmo_cnt_q != '0) begin
                tmo_cnt_q <= tmo_cnt_q - TW'(1);
            end
        end
    end

    // shift_q cannot change the cycle after a stop fe, so it feeds the FIFO directly
    ps2_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (clr_i),
        .push_i  (push_q),
        .din_i   (shift_q),
        .pop_i   (rd_i),
        .dout_o  (data_o),
        .valid_o (valid_o),
        .count_o (count_o),
        .ovf_o   (fifo_ovf)
    );

    assign par_err_o = par_err_q;
    assign frm_err_o = frm_q;
    assign ovf_o     = ovf_q;
    assign irq_o     = valid_o;

endmodule

// File: tb/tb_ps2_host_rx.sv
// Scoreboarded bench for ps2_host_rx: a PS/2 device model drives frames while
// a monitor compares popped bytes and error pulses against queued predictions.
module tb_ps2_host_rx;
    localparam int DEPTH = 8;
    localparam int FILT  = 4;
    localparam int TMO   = 200;
    localparam int HALF  = 20;

    localparam int K_PAR = 1;
    localparam int K_FRM = 2;
    localparam int K_OVF = 3;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       en_i = 1'b1;
    logic       clr_i = 1'b0;
    logic       ps2_clk_i = 1'b1;
    logic       ps2_dat_i = 1'b1;
    logic       rd_i = 1'b0;
    logic [7:0] data_o;
    logic       valid_o;
    logic [3:0] count_o;
    logic       par_err_o, frm_err_o, ovf_o, irq_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_fall = 0;
    int last_frm_cyc = -1;
    logic [7:0] last_popped = 8'h00;

    logic [7:0] exp_q[$];
    int         err_q[$];

    ps2_host_rx #(
        .FIFO_DEPTH  (DEPTH),
        .FILT_LEN    (FILT),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .en_i      (en_i),
        .clr_i     (clr_i),
        .ps2_clk_i (ps2_clk_i),
        .ps2_dat_i (ps2_dat_i),
        .rd_i      (rd_i),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .count_o   (count_o),
        .par_err_o (par_err_o),
        .frm_err_o (frm_err_o),
        .ovf_o     (ovf_o),
        .irq_o     (irq_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // Monitor: pulses pop the error queue, FIFO pops pop the byte queue
    always @(negedge clk_i) begin
        int np;
        int kind;
        int e;
        logic [7:0] b;
        if (rst_n_i) begin
            np = int'(par_err_o) + int'(frm_err_o) + int'(ovf_o);
            if (np > 1) begin
                checks++;
                errors++;
                $display("FAIL pulse_excl: par=%0b frm=%0b ovf=%0b, required at most one",
                         par_err_o, frm_err_o, ovf_o);
            end else if (np == 1) begin
                kind = par_err_o ? K_PAR : (frm_err_o ? K_FRM : K_OVF);
                if (frm_err_o) last_frm_cyc = cyc;
                checks++;
                if (err_q.size() == 0) begin
                    errors++;
                    $display("FAIL pulse_unexp: got kind %0d, required no pulse", kind);
                end else begin
                    e = err_q.pop_front();
                    if (e != kind) begin
                        errors++;
                        $display("FAIL pulse_kind: got kind %0d, required %0d", kind, e);
                    end
                end
            end
            if (rd_i && valid_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_unexp: got byte %02h, required empty FIFO", data_o);
                end else begin
                    b = exp_q.pop_front();
                    last_popped = b;
                    if (data_o !== b || irq_o !== 1'b1) begin
                        errors++;
                        $display("FAIL pop_data: got %02h irq=%0b, required %02h irq=1",
                                 data_o, irq_o, b);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Reference outcome of one complete frame, from the frame rules alone
    task automatic predict(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                           input bit pop_planned);
        if (bad_stop)                                   err_q.push_back(K_FRM);
        else if (bad_par)                               err_q.push_back(K_PAR);
        else if (exp_q.size() >= DEPTH && !pop_planned) err_q.push_back(K_OVF);
        else                                            exp_q.push_back(b);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int glitch_bit, input bit pop_at_stop, input int nbits);
        logic [10:0] fr;
        logic        par;
        par = bad_par ? (^b) : ~(^b);
        fr  = {~bad_stop, par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_dat_i = fr[i];
            if (i == glitch_bit) begin
                wait_cyc(HALF / 2);
                ps2_clk_i = 1'b0;
                wait_cyc(2);
                ps2_clk_i = 1'b1;
                wait_cyc(HALF - HALF / 2 - 2);
            end else begin
                wait_cyc(HALF);
            end
            ps2_clk_i = 1'b0;
            last_fall = cyc;
            if (i == 10 && pop_at_stop) begin
                repeat (2 + FILT) @(posedge clk_i);
                #1 rd_i = 1'b1;
                @(posedge clk_i);
                #1 rd_i = 1'b0;
                wait_cyc(HALF - FILT - 3);
            end else begin
                wait_cyc(HALF);
            end
            ps2_clk_i = 1'b1;
        end
        ps2_dat_i = 1'b1;
        wait_cyc(3 * HALF);
    endtask

    task automatic frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        predict(b, bad_par, bad_stop, 1'b0);
        send_frame(b, bad_par, bad_stop, -1, 1'b0, 11);
    endtask

    task automatic drain(input string nm);
        int n;
        n = exp_q.size();
        if (n > 0) begin
            rd_i = 1'b1;
            repeat (n) @(posedge clk_i);
            #1 rd_i = 1'b0;
        end
        rd_i = 1'b1;
        wait_cyc(1);
        rd_i = 1'b0;
        wait_cyc(2);
        chk({nm, "_valid"}, {31'd0, valid_o}, 32'd0);
        chk({nm, "_count"}, {28'd0, count_o}, 32'd0);
        chk({nm, "_hold"}, {24'd0, data_o}, {24'd0, last_popped});
    endtask

    initial begin
        logic [7:0] rb;
        int r;
        int d;
        wait_cyc(3);
        chk("rst_data", {24'd0, data_o}, 32'd0);
        chk("rst_flags", {26'd0, valid_o, irq_o, par_err_o, frm_err_o, ovf_o, 1'b0}, 32'd0);
        chk("rst_count", {28'd0, count_o}, 32'd0);
        rst_n_i = 1'b1;
        wait_cyc(5);

        frame(8'h41, 1'b0, 1'b0);
        chk("one_count", {28'd0, count_o}, 32'd1);
        chk("one_data", {24'd0, data_o}, 32'h41);
        chk("one_irq", {30'd0, valid_o, irq_o}, 32'd3);
        drain("one");

        frame(8'h41, 1'b1, 1'b0);
        chk("par_count", {28'd0, count_o}, 32'd0);
        frame(8'h5A, 1'b0, 1'b0);
        chk("after_par_data", {24'd0, data_o}, 32'h5A);
        drain("par");

        for (int i = 0; i < 9; i++) frame(8'h10 + 8'(i), 1'b0, 1'b0);
        chk("full_count", {28'd0, count_o}, 32'd8);
        drain("full");

        err_q.push_back(K_FRM);
        last_frm_cyc = -1;
        send_frame(8'h0F, 1'b0, 1'b0, -1, 1'b0, 4);
        wait_cyc(TMO + 20);
        d = last_frm_cyc - last_fall;
        chk("tmo_latency", {31'd0, (d >= TMO + FILT + 1 && d <= TMO + FILT + 3)}, 32'd1);
        frame(8'h5A, 1'b0, 1'b0);
        chk("after_tmo_data", {24'd0, data_o}, 32'h5A);
        drain("tmo");

        predict(8'h33, 1'b0, 1'b0, 1'b0);
        send_frame(8'h33, 1'b0, 1'b0, 4, 1'b0, 11);
        chk("glitch_count", {28'd0, count_o}, 32'd1);
        frame(8'h33, 1'b0, 1'b1);
        chk("badstop_count", {28'd0, count_o}, 32'd1);
        drain("glitch");

        for (int i = 0; i < 8; i++) frame(8'h20 + 8'(i), 1'b0, 1'b0);
        predict(8'hA5, 1'b0, 1'b0, 1'b1);
        send_frame(8'hA5, 1'b0, 1'b0, -1, 1'b1, 11);
        chk("pushpop_count", {28'd0, count_o}, 32'd8);
        drain("pushpop");

        frame(8'hC3, 1'b0, 1'b0);
        frame(8'h3C, 1'b0, 1'b0);
        chk("preclr_count", {28'd0, count_o}, 32'd2);
        last_popped = 8'hC3;
        clr_i = 1'b1;
        wait_cyc(1);
        clr_i = 1'b0;
        wait_cyc(1);
        exp_q.delete();
        chk("clr_count", {28'd0, count_o}, 32'd0);
        chk("clr_valid", {31'd0, valid_o}, 32'd0);

        send_frame(8'h99, 1'b0, 1'b0, -1, 1'b0, 5);
        en_i = 1'b0;
        wait_cyc(5);
        en_i = 1'b1;
        wait_cyc(TMO + 20);
        frame(8'h7E, 1'b0, 1'b0);
        chk("en_data", {24'd0, data_o}, 32'h7E);
        drain("en");

        frame(8'h55, 1'b0, 1'b0);
        send_frame(8'hE7, 1'b0, 1'b0, -1, 1'b0, 5);
        ps2_dat_i = 1'b0;
        ps2_clk_i = 1'b0;
        rst_n_i = 1'b0;
        #2;
        chk("rstmid_count", {28'd0, count_o}, 32'd0);
        chk("rstmid_flags", {27'd0, valid_o, irq_o, par_err_o, frm_err_o, ovf_o}, 32'd0);
        chk("rstmid_data", {24'd0, data_o}, 32'd0);
        exp_q.delete();
        last_popped = 8'h00;
        ps2_dat_i = 1'b1;
        ps2_clk_i = 1'b1;
        wait_cyc(3);
        rst_n_i = 1'b1;
        wait_cyc(5);
        frame(8'h6B, 1'b0, 1'b0);
        chk("rstmid_next", {24'd0, data_o}, 32'h6B);
        drain("rstmid");

        for (int i = 0; i < 24; i++) begin
            rb = 8'($urandom);
            r  = $urandom_range(0, 9);
            frame(rb, (r == 1 || r == 2), (r == 0));
            if (exp_q.size() >= 6 && $urandom_range(0, 1) == 1) drain("rand");
        end
        drain("final");

        chk("err_q_empty", err_q.size(), 32'd0);
        chk("exp_q_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_host_rx.md
Name: ps2_host_rx

Overview:
- Host-side PS/2 receiver, the counterpart of the keyboard/device transmitter. Receives device-to-host frames on ps2_clk/ps2_dat.
- Frame format: start 0, 8 data bits LSB-first, odd parity, stop 1.
- Valid bytes are buffered in a small FWFT FIFO for the peripheral bus wrapper.
- Lives in the SoC peripheral subsystem next to the UART and I2C blocks; irq_o feeds the interrupt controller.

Parameters:
- FIFO_DEPTH, 8: byte FIFO entries. Power of 2, minimum 2.
- FILT_LEN, 4: consecutive stable system-clock samples needed to accept a new ps2_clk level.
- TIMEOUT_CYC, 4800: system clocks with no falling edge mid-frame before the frame is aborted (200 us at 24 MHz).

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- en_i  in  1  receiver enable
- clr_i  in  1  synchronous FIFO flush pulse
- ps2_clk_i  in  1  PS/2 clock pad input, asynchronous
- ps2_dat_i  in  1  PS/2 data pad input, asynchronous
- rd_i  in  1  pop strobe
- data_o  out  8  FIFO head byte
- valid_o  out  1  FIFO not empty
- count_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- par_err_o  out  1  one-cycle pulse on a parity error
- frm_err_o  out  1  one-cycle pulse on a bad start/stop bit or timeout
- ovf_o  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full
- irq_o  out  1  level, equal to valid_o

Behaviour:
- Reset (async assert, sync release): FSM IDLE, FIFO empty; data_o=0, valid_o=0, count_o=0, all pulses 0, irq_o=0. Synchronisers reset to 1 (idle bus level).
- Input conditioning:
  - Both pads pass through 2-FF synchronisers.
  - The ps2_clk filter level changes only after FILT_LEN consecutive identical synced samples.
  - A falling edge (fe) is a filtered 1->0 transition, one cycle wide.
  - Data is sampled from the synced ps2_dat on the fe cycle.
- FSM states and transitions:
  - IDLE: on fe with dat=0, go to DATA with bit count 0. On fe with dat=1, stay in IDLE and pulse frm_err_o.
  - DATA: on each fe shift dat into bit (count) of the shift register, LSB first. After the 8th bit go to PARITY.
  - PARITY: on fe latch the parity bit and go to STOP.
  - STOP: on fe evaluate the frame and return to IDLE.
- Frame evaluation (STOP fe):
  - stop=0: pulse frm_err_o, no push. This takes priority over a parity error.
  - XOR(data,parity)=0: pulse par_err_o, no push.
  - Otherwise push the byte.
  - The push happens on the cycle after the stop fe; valid_o rises the cycle after that.
- Timeout:
  - The idle counter is cleared on every fe and counts only in non-IDLE states.
  - On reaching TIMEOUT_CYC: return to IDLE, pulse frm_err_o, discard the partial byte.
- Enable: en_i=0 forces IDLE and aborts any partial frame with no error pulse. The FIFO is retained and remains poppable.
- FIFO (first-word fall-through):
  - data_o is the head byte whenever valid_o=1, and holds its last value when empty.
  - A pop is rd_i && valid_o. rd_i while empty is ignored.
  - Push with full and no pop: byte dropped, ovf_o pulses, contents unchanged.
  - Push and pop in the same cycle: both happen and count is unchanged, including when full (no ovf).
  - Pointers wrap modulo FIFO_DEPTH; count_o ranges 0..FIFO_DEPTH.
  - clr_i empties the FIFO next cycle. It beats a simultaneous push or pop, and the pushed byte is lost without ovf.
- Simultaneous events: par_err_o, frm_err_o and ovf_o are mutually exclusive per frame. A timeout and an fe in the same cycle: the fe wins and the counter clears.
- Reset mid-frame: everything returns to reset values immediately; the partial frame is lost with no pulse.

Decomposition:
- Shared package ps2_pkg holds:
  - typedef enum ps2_rx_state_e {IDLE, DATA, PARITY, STOP} (2-bit)
  - constants PS2_DATA_BITS=8, PS2_START=0, PS2_STOP=1
  - default FILT_LEN and TIMEOUT_CYC localparams for reuse by a future host transmitter
- Sub-module ps2_rx_fifo: parameterised synchronous FWFT byte FIFO with push/pop/clr, full/empty and count.
- Synchroniser, filter and FSM stay in ps2_host_rx.

Test Plan:
- Device sends 0x41 at 12.5 kHz, odd parity=1, stop=1 -> valid_o=1, data_o=0x41, count_o=1, irq_o=1. Pop -> valid_o=0 the next cycle.
- Device sends 0x41 with parity=0 -> one par_err_o pulse, count_o stays 0. A following 0x5A with correct parity -> data_o=0x5A.
- Nine good frames 0x10..0x18 with no pops (DEPTH=8) -> ovf_o pulses once on 0x18, count_o=8. Eight pops return 0x10..0x17 in order.
- Start bit plus 3 data bits, then clock held high -> frm_err_o exactly TIMEOUT_CYC cycles after the last fe. A following 0x5A frame is received correctly.
- 2-cycle low glitch on ps2_clk_i mid-frame with FILT_LEN=4 -> no bit consumed, frame 0x33 received intact. A stop bit of 0 on frame 0x33 -> frm_err_o pulse, no push.
- FIFO full, stop fe coincides with rd_i -> no ovf_o, count_o stays 8, new byte at the tail. rst_n_i low mid-frame -> all outputs 0, next frame received normally.
